// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding, default widths and
// the packed stage word carried between pipeline stages.
package pipe_pkg;

    localparam int unsigned PipePcW   = 32;
    localparam int unsigned PipeDataW = 32;
    localparam int unsigned PipeCtrlW = 4;
    localparam int unsigned PipeCntW  = 16;

    // Encoding equals the number of held entries, so the state doubles as occupancy.
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    typedef logic [1:0] pipe_state_t;

    typedef struct packed {
        logic [PipePcW-1:0]   pc;
        logic [PipeDataW-1:0] data;
        logic [PipeCtrlW-1:0] ctrl;
    } pipe_word_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: counts qualifying cycles and sticks at all-ones.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = PipeCntW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a one-entry skid buffer; in_ready_o depends on state only.
// Optional stall/bubble counters are built when PIPE_SKID_PERF_EN is defined.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned PC_W   = PipePcW,
    parameter int unsigned DATA_W = PipeDataW,
    parameter int unsigned CTRL_W = PipeCtrlW,
    parameter int unsigned CNT_W  = PipeCntW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   in_pc_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
`ifdef PIPE_SKID_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
    output logic [1:0]        occupancy_o
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } word_t;

    pipe_state_t state_d, state_q;
    word_t       main_d, main_q;
    word_t       skid_d, skid_q;
    word_t       in_word;
    logic        push, pop;

    assign in_word = {in_pc_i, in_data_i, in_ctrl_i};

    assign in_ready_o  = (state_q != StTwo);
    assign out_valid_o = (state_q != StEmpty);
    assign occupancy_o = state_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        main_d  = in_word;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_d = in_word;
                    end else if (push) begin
                        skid_d  = in_word;
                        state_d = StTwo;
                    end else if (pop) begin
                        main_d  = '0;
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = StOne;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Gate payload so bubbles never leak stale enables downstream.
    assign out_pc_o   = out_valid_o ? main_q.pc   : '0;
    assign out_data_o = out_valid_o ? main_q.data : '0;
    assign out_ctrl_o = out_valid_o ? main_q.ctrl : '0;

`ifdef PIPE_SKID_PERF_EN
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (out_valid_o & ~out_ready_i),
        .count_o (stall_cnt_o)
    );

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (~out_valid_o),
        .count_o (bubble_cnt_o)
    );
`endif

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised elastic pipeline stage register with valid/ready handshake and a one-entry skid buffer. Carries PC, payload data and control bits between any two pipeline stages. Supports a full-throughput flow, backpressure without combinational ready paths, and a flush that clears everything in flight. It is the generic successor to the fixed inter-stage registers and is instantiated once per stage boundary.

## Interface
- PC_W, 32, PC field width
- DATA_W, 32, payload width (ALU result, store data, forwarding info packed by instantiator)
- CTRL_W, 4, control bits (WB/M enables); forced to 0 on bubbles
- CNT_W, 16, perf counter width (used only with PIPE_SKID_PERF_EN)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush of both entries
- in_valid_i  in  1  upstream has a word
- in_ready_o  out  1  stage can accept; registered
- in_pc_i / in_data_i / in_ctrl_i  in  PC_W / DATA_W / CTRL_W  upstream word
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  downstream accepts head
- out_pc_o / out_data_o / out_ctrl_o  out  PC_W / DATA_W / CTRL_W  head word
- occupancy_o  out  2  entries held (0..2)
- stall_cnt_o  out  CNT_W  cycles with out_valid_o & !out_ready_i (PERF only)
- bubble_cnt_o  out  CNT_W  cycles with !out_valid_o (PERF only)

## Operation
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- Entries: main (drives outputs) and skid. States EMPTY, ONE, TWO.
- EMPTY: push -> ONE, main <= in.
- ONE: push & pop -> ONE, main <= in; push & !pop -> TWO, skid <= in; pop only -> EMPTY; neither -> hold.
- TWO: pop -> ONE, main <= skid; else hold. No push possible.
- in_ready_o = (state != TWO), derived from the state register only; no combinational path from out_ready_i.
- out_valid_o = (state != EMPTY); occupancy_o = 0/1/2.
- out_ctrl_o and out_pc_o are 0 whenever out_valid_o is 0. out_data_o is also 0 in that case.
- Priority: reset > flush > handshake. Flush -> EMPTY, both entries zeroed, any same-cycle push discarded, pop irrelevant.
- Order preserved; no word is lost or duplicated except under flush.

## Timing
- Reset: state EMPTY, in_ready_o=1, out_valid_o=0, all payload outputs 0, occupancy_o=0, counters 0.
- Latency: 1 cycle from accepted push to out_valid_o when EMPTY or when ONE with a same-cycle pop.
- Throughput: 1 word/cycle sustained while out_ready_i=1.
- in_ready_o drops the cycle after the push that fills skid. It rises the cycle after the pop from TWO.
- Flush takes effect at the next edge. Outputs are 0/invalid in the following cycle, and in_ready_o=1.
- Reset asserted mid-operation clears immediately, asynchronously. Deassertion is synchronised externally.

## Configuration
- PIPE_SKID_PERF_EN defined: stall_cnt_o and bubble_cnt_o are present.
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W-1, with no wrap.
  - Counters are cleared only by reset; flush does not affect them.
  - A flush cycle counts normally based on pre-edge outputs.
- Undefined: both ports and counters are absent, and there is no extra logic.

## Structure
- Shared package pipe_pkg: state enum (EMPTY/ONE/TWO), default width constants, packed stage-word typedef {pc, data, ctrl}.
- Sub-module pipe_sat_counter (CNT_W, inc_i, count_o) is instantiated twice under PIPE_SKID_PERF_EN.

## Test plan
- Streaming: out_ready_i=1, push pc=0x100,0x104,0x108 on consecutive cycles -> same sequence appears one cycle later, occupancy_o stays 1, in_ready_o stays 1.
- Backpressure: out_ready_i=0, push 0x200 then 0x204 -> occupancy 2, in_ready_o=0. A third in_valid_i is ignored. Raise out_ready_i -> 0x200 then 0x204 are output, in_ready_o=1 after first pop.
- Flush in TWO with concurrent push of 0x300 -> next cycle out_valid_o=0, out_ctrl_o=0, occupancy 0, and 0x300 never appears.
- Async reset mid-stream (rst_i low between edges) -> outputs immediately 0, in_ready_o=1.
- Bubble control: push ctrl=4'hF then idle with out_ready_i=1 -> after pop, out_ctrl_o=0 while out_valid_o=0.
- PERF, CNT_W=4: hold a valid head with out_ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15. A flush leaves stall_cnt_o at 15.
